// File: rtl/reg_mst_pkg.sv
// Shared types and default widths for the register master.
package reg_mst_pkg;

  localparam int unsigned DefAddrWidth = 64;
  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefToWidth   = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StAbort = 2'd2,
    StResp  = 2'd3
  } reg_mst_state_e;

endpackage

// File: rtl/reg_mst_fsm_if.sv
// Request/acknowledge bus between the register master and the slave-side FSM.
interface reg_mst_fsm_if #(
  parameter int unsigned ADDR_WIDTH = reg_mst_pkg::DefAddrWidth,
  parameter int unsigned DATA_WIDTH = reg_mst_pkg::DefDataWidth
) ();

  logic                  req_vld;
  logic                  ack_vld;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  sync_reset;

  modport master (
    output req_vld, addr, wr_en, rd_en, wr_data, sync_reset,
    input  ack_vld, rd_data
  );

  modport slave (
    input  req_vld, addr, wr_en, rd_en, wr_data, sync_reset,
    output ack_vld, rd_data
  );

endinterface

// File: rtl/reg_mst_timer.sv
// Loadable down-counter; expire flags the last enabled cycle of a non-zero count.
module reg_mst_timer #(
  parameter int unsigned WIDTH = reg_mst_pkg::DefToWidth
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] value,
  output logic             expire
);

  logic [WIDTH-1:0] count_q;

  // A loaded zero never counts, which is what disables the timeout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign expire = en && (count_q == WIDTH'(1));

endmodule

// File: rtl/reg_mst_fsm.sv
// Register-bus initiator: one command in flight, ack or timeout, then a response.
module reg_mst_fsm
  import reg_mst_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned TO_WIDTH   = DefToWidth
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wr_data,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rd_data,
  output logic                  rsp_err,
  input  logic [TO_WIDTH-1:0]   cfg_timeout,
  input  logic                  soft_clr,
  output logic                  busy,
  reg_mst_fsm_if.master         bus
);

  reg_mst_state_e state_q;
  logic           timer_load;
  logic           timer_expire;

  assign timer_load = (state_q == StIdle) && cmd_vld && !soft_clr;

  reg_mst_timer #(
    .WIDTH(TO_WIDTH)
  ) u_timer (
    .clk   (clk),
    .rstn  (rstn),
    .load  (timer_load),
    .en    (state_q == StReq),
    .value (cfg_timeout),
    .expire(timer_expire)
  );

  assign cmd_rdy        = (state_q == StIdle);
  assign busy           = (state_q != StIdle);
  assign bus.sync_reset = soft_clr || (state_q == StAbort);

  // Command/response state machine with registered bus and response outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      bus.req_vld <= 1'b0;
      bus.addr    <= '0;
      bus.wr_en   <= 1'b0;
      bus.rd_en   <= 1'b0;
      bus.wr_data <= '0;
      rsp_vld     <= 1'b0;
      rsp_rd_data <= '0;
      rsp_err     <= 1'b0;
    end else if (soft_clr) begin
      // Drops any in-flight command or pending response; beats ack and accept.
      state_q     <= StIdle;
      bus.req_vld <= 1'b0;
      bus.addr    <= '0;
      bus.wr_en   <= 1'b0;
      bus.rd_en   <= 1'b0;
      bus.wr_data <= '0;
      rsp_vld     <= 1'b0;
      rsp_rd_data <= '0;
      rsp_err     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cmd_vld) begin
            bus.req_vld <= 1'b1;
            bus.addr    <= cmd_addr;
            bus.wr_en   <= cmd_wr;
            bus.rd_en   <= !cmd_wr;
            bus.wr_data <= cmd_wr_data;
            state_q     <= StReq;
          end
        end
        StReq: begin
          // Ack is checked first so it wins a tie with the expiring timer.
          if (bus.ack_vld || timer_expire) begin
            bus.req_vld <= 1'b0;
            bus.addr    <= '0;
            bus.wr_en   <= 1'b0;
            bus.rd_en   <= 1'b0;
            bus.wr_data <= '0;
          end
          if (bus.ack_vld) begin
            rsp_rd_data <= bus.rd_en ? bus.rd_data : '0;
            rsp_err     <= 1'b0;
            rsp_vld     <= 1'b1;
            state_q     <= StResp;
          end else if (timer_expire) begin
            state_q <= StAbort;
          end
        end
        StAbort: begin
          rsp_rd_data <= '0;
          rsp_err     <= 1'b1;
          rsp_vld     <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          if (rsp_rdy) begin
            rsp_vld     <= 1'b0;
            rsp_rd_data <= '0;
            rsp_err     <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_mst_fsm.sv
// Directed bench for reg_mst_fsm with a transaction-level reference model.
module tb_reg_mst_fsm;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 16;

  logic          clk         = 1'b0;
  logic          rstn        = 1'b1;
  logic          cmd_vld     = 1'b0;
  logic          cmd_wr      = 1'b0;
  logic [AW-1:0] cmd_addr    = '0;
  logic [DW-1:0] cmd_wr_data = '0;
  logic          rsp_rdy     = 1'b1;
  logic [TW-1:0] cfg_timeout = '0;
  logic          soft_clr    = 1'b0;
  logic          cmd_rdy, rsp_vld, rsp_err, busy;
  logic [DW-1:0] rsp_rd_data;

  reg_mst_fsm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  reg_mst_fsm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TO_WIDTH(TW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cmd_vld    (cmd_vld),
    .cmd_rdy    (cmd_rdy),
    .cmd_wr     (cmd_wr),
    .cmd_addr   (cmd_addr),
    .cmd_wr_data(cmd_wr_data),
    .rsp_vld    (rsp_vld),
    .rsp_rdy    (rsp_rdy),
    .rsp_rd_data(rsp_rd_data),
    .rsp_err    (rsp_err),
    .cfg_timeout(cfg_timeout),
    .soft_clr   (soft_clr),
    .busy       (busy),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the command in flight, a pending abort pulse, a pending response.
  bit            m_inflight, m_abort, m_rsp, m_wr, m_rsp_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_rsp_data;
  int            m_to, m_age;

  function automatic bit m_idle();
    return !m_inflight && !m_abort && !m_rsp;
  endfunction

  task automatic m_clear();
    m_inflight = 0; m_abort = 0; m_rsp = 0; m_rsp_err = 0;
    m_addr = '0; m_data = '0; m_rsp_data = '0; m_wr = 0; m_age = 0; m_to = 0;
  endtask

  // Advance the model on each clock using the inputs seen at that edge.
  always @(posedge clk or negedge rstn) begin
    if (!rstn || soft_clr) begin
      m_clear();
    end else if (m_idle()) begin
      if (cmd_vld) begin
        m_inflight = 1; m_wr = cmd_wr; m_addr = cmd_addr; m_data = cmd_wr_data;
        m_to = int'(cfg_timeout); m_age = 0;
      end
    end else if (m_inflight) begin
      m_age++;
      if (bus.ack_vld) begin
        m_inflight = 0; m_rsp = 1; m_rsp_err = 0;
        m_rsp_data = m_wr ? '0 : bus.rd_data;
      end else if (m_to != 0 && m_age == m_to) begin
        m_inflight = 0; m_abort = 1;
      end
    end else if (m_abort) begin
      m_abort = 0; m_rsp = 1; m_rsp_err = 1; m_rsp_data = '0;
    end else if (m_rsp && rsp_rdy) begin
      m_rsp = 0;
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    chk("cmd_rdy", cmd_rdy, m_idle());
    chk("busy", busy, !m_idle());
    chk("req_vld", bus.req_vld, m_inflight);
    chk("addr", bus.addr, m_inflight ? m_addr : '0);
    chk("wr_en", bus.wr_en, m_inflight && m_wr);
    chk("rd_en", bus.rd_en, m_inflight && !m_wr);
    chk("wr_data", bus.wr_data, m_inflight ? m_data : '0);
    chk("sync_reset", bus.sync_reset, m_abort || soft_clr);
    chk("rsp_vld", rsp_vld, m_rsp);
    chk("rsp_rd_data", rsp_rd_data, m_rsp ? m_rsp_data : '0);
    chk("rsp_err", rsp_err, m_rsp && m_rsp_err);
  end

  // Running cycle counts used by the literal expectations.
  int req_cnt = 0, rd_cnt = 0, wr_cnt = 0, sync_cnt = 0, rsp_cnt = 0;
  always @(negedge clk) begin
    if (bus.req_vld === 1'b1) req_cnt++;
    if (bus.rd_en === 1'b1) rd_cnt++;
    if (bus.wr_en === 1'b1) wr_cnt++;
    if (bus.sync_reset === 1'b1) sync_cnt++;
    if (rsp_vld === 1'b1) rsp_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for a single accepting edge; returns in the first REQ cycle.
  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [TW-1:0] to);
    chk("issue_cmd_rdy", cmd_rdy, 1'b1);
    cmd_vld = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wr_data = d; cfg_timeout = to;
    tick();
    cmd_vld = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wr_data = '0;
  endtask

  task automatic wait_rsp(input int budget);
    int i = 0;
    while (rsp_vld !== 1'b1 && i < budget) begin
      tick();
      i++;
    end
    chk("rsp_wait", rsp_vld, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    int r0, q0, w0, s0, p0;
    bus.ack_vld = 1'b0;
    bus.rd_data = '0;
    #1 rstn = 1'b0;
    #1;
    chk("reset_cmd_rdy", cmd_rdy, 1'b1);
    chk("reset_req_vld", bus.req_vld, 1'b0);
    chk("reset_rsp_vld", rsp_vld, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_rsp_rd_data", rsp_rd_data, '0);
    repeat (2) tick();
    rstn = 1'b1;
    tick();

    // Read, ack in the second REQ cycle.
    r0 = req_cnt; q0 = rd_cnt;
    issue(1'b0, 64'h40, 32'h0, 16'd0);
    tick();
    bus.ack_vld = 1'b1; bus.rd_data = 32'hDEAD_BEEF;
    tick();
    bus.ack_vld = 1'b0; bus.rd_data = '0;
    chk("rd_rsp_vld", rsp_vld, 1'b1);
    chk("rd_rsp_data", rsp_rd_data, 32'hDEAD_BEEF);
    chk("rd_rsp_err", rsp_err, 1'b0);
    chk("rd_req_cycles", req_cnt - r0, 2);
    chk("rd_rd_en_cycles", rd_cnt - q0, 2);
    tick();

    // Write, ack in the first REQ cycle: response at T+2.
    w0 = wr_cnt;
    issue(1'b1, 64'h100, 32'h1234, 16'd0);
    bus.ack_vld = 1'b1; bus.rd_data = 32'hFFFF_FFFF;
    tick();
    bus.ack_vld = 1'b0; bus.rd_data = '0;
    chk("wr_rsp_vld", rsp_vld, 1'b1);
    chk("wr_rsp_data", rsp_rd_data, 32'h0);
    chk("wr_rsp_err", rsp_err, 1'b0);
    chk("wr_wr_en_cycles", wr_cnt - w0, 1);
    tick();

    // Timeout of 5 with no ack.
    rsp_rdy = 1'b0; r0 = req_cnt; s0 = sync_cnt;
    issue(1'b0, 64'h80, 32'h0, 16'd5);
    wait_rsp(20);
    chk("to5_rsp_err", rsp_err, 1'b1);
    chk("to5_rsp_data", rsp_rd_data, 32'h0);
    chk("to5_req_cycles", req_cnt - r0, 5);
    chk("to5_sync_pulses", sync_cnt - s0, 1);
    rsp_rdy = 1'b1;
    tick();

    // Timeout of 5 with ack on the 5th REQ cycle: ack wins.
    r0 = req_cnt; s0 = sync_cnt;
    issue(1'b0, 64'h88, 32'h0, 16'd5);
    repeat (4) tick();
    bus.ack_vld = 1'b1; bus.rd_data = 32'hA5A5_0005;
    tick();
    bus.ack_vld = 1'b0; bus.rd_data = '0;
    chk("tie_rsp_vld", rsp_vld, 1'b1);
    chk("tie_rsp_err", rsp_err, 1'b0);
    chk("tie_rsp_data", rsp_rd_data, 32'hA5A5_0005);
    chk("tie_req_cycles", req_cnt - r0, 5);
    chk("tie_sync_pulses", sync_cnt - s0, 0);
    tick();

    // Smallest enabled timeout.
    r0 = req_cnt; s0 = sync_cnt;
    issue(1'b1, 64'h90, 32'h55, 16'd1);
    wait_rsp(10);
    chk("to1_rsp_err", rsp_err, 1'b1);
    chk("to1_req_cycles", req_cnt - r0, 1);
    chk("to1_sync_pulses", sync_cnt - s0, 1);
    tick();

    // soft_clr in REQ together with an ack.
    p0 = rsp_cnt;
    issue(1'b0, 64'h48, 32'h0, 16'd0);
    tick();
    soft_clr = 1'b1; bus.ack_vld = 1'b1; bus.rd_data = 32'h1111_1111;
    #1;
    chk("clr_sync_reset", bus.sync_reset, 1'b1);
    tick();
    soft_clr = 1'b0; bus.ack_vld = 1'b0; bus.rd_data = '0;
    chk("clr_cmd_rdy", cmd_rdy, 1'b1);
    chk("clr_req_vld", bus.req_vld, 1'b0);
    repeat (3) tick();
    chk("clr_no_rsp", rsp_cnt - p0, 0);

    // Response stall of 4 cycles with a spurious ack.
    rsp_rdy = 1'b0;
    issue(1'b0, 64'h44, 32'h0, 16'd0);
    bus.ack_vld = 1'b1; bus.rd_data = 32'hCAFE_F00D;
    tick();
    bus.ack_vld = 1'b0; bus.rd_data = '0;
    for (int i = 0; i < 4; i++) begin
      chk("stall_rsp_vld", rsp_vld, 1'b1);
      chk("stall_rsp_data", rsp_rd_data, 32'hCAFE_F00D);
      chk("stall_cmd_rdy", cmd_rdy, 1'b0);
      if (i == 1) begin
        bus.ack_vld = 1'b1; bus.rd_data = 32'h0000_0BAD;
      end
      tick();
      bus.ack_vld = 1'b0; bus.rd_data = '0;
    end
    rsp_rdy = 1'b1;
    tick();
    chk("stall_done_rsp_vld", rsp_vld, 1'b0);
    chk("stall_done_cmd_rdy", cmd_rdy, 1'b1);

    // Asynchronous reset mid-request.
    issue(1'b1, 64'h50, 32'h77, 16'd0);
    #2 rstn = 1'b0;
    #1;
    chk("areset_cmd_rdy", cmd_rdy, 1'b1);
    chk("areset_req_vld", bus.req_vld, 1'b0);
    chk("areset_busy", busy, 1'b0);
    tick();
    rstn = 1'b1;
    tick();
    chk("areset_idle", cmd_rdy, 1'b1);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
